// File: rtl/scan_seq_pkg.sv
// scan_seq shared definitions: FSM encodings, index count, counter sizing.
// Consumed by scan_seq and scan_tick (SCAN_SEQ_BLANK_EN selects blanking).
package scan_pkg;

    localparam logic [1:0] SCAN_IDLE  = 2'd0;
    localparam logic [1:0] SCAN_SHOW  = 2'd1;
    localparam logic [1:0] SCAN_BLANK = 2'd2;

    localparam int SCAN_N = 4;

    function automatic int scan_cw(int a, int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/scan_seq_if.sv
// Frame-load handshake and decoder-drive bundle for scan_seq.
interface scan_seq_if #(
    parameter int W = 4
);
    logic           load_valid;
    logic [4*W-1:0] load_data;
    logic           load_ready;
    logic [1:0]     sel;
    logic           sel_en;
    logic [W-1:0]   digit;
    logic           frame_done;

    modport master (
        output load_valid, load_data,
        input  load_ready, sel, sel_en, digit, frame_done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, sel, sel_en, digit, frame_done
    );
endinterface

// File: rtl/scan_seq_tick.sv
// scan_tick: dwell counter with one-cycle terminal-count pulse.
// SCAN_SEQ_BLANK_EN adds the BLANK terminal count and its select input.
module scan_tick
    import scan_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
`ifdef SCAN_SEQ_BLANK_EN
    input  logic tsel,
`endif
    output logic tc
);

    localparam int CW = scan_cw(DIV, BLANK);

    logic [CW-1:0] cnt;
    logic [CW-1:0] term;

`ifdef SCAN_SEQ_BLANK_EN
    assign term = tsel ? CW'(BLANK - 1) : CW'(DIV - 1);
`else
    assign term = CW'(DIV - 1);
`endif

    // equality compare only: the count restarts instead of wrapping
    assign tc = en && (cnt == term);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/scan_seq.sv
// scan_seq: 4-way scan sequencer with double-buffered frame.
// Define SCAN_SEQ_BLANK_EN to insert BLANK dark cycles after each index.
module scan_seq
    import scan_pkg::*;
#(
    parameter int DIV   = 1000,
    parameter int BLANK = 16,
    parameter int W     = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    scan_seq_if.slave bus
);

    logic [1:0]     state;
    logic [1:0]     state_n;
    logic [1:0]     sel_n;
    logic           sel_en_n;
    logic           fd_n;
    logic           promote;
    logic           step;
    logic           tc;
    logic           clr;
    logic [4*W-1:0] active;
    logic [4*W-1:0] active_n;
    logic [4*W-1:0] shadow;
    logic           shadow_full;
    logic [W-1:0]   digit_n;

    assign bus.load_ready = !shadow_full;
    assign clr = (state == SCAN_IDLE) || !start;

    scan_tick #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != SCAN_IDLE),
        .clr  (clr),
`ifdef SCAN_SEQ_BLANK_EN
        .tsel (state == SCAN_BLANK),
`endif
        .tc   (tc)
    );

    always_comb begin
        state_n  = state;
        sel_n    = bus.sel;
        sel_en_n = bus.sel_en;
        fd_n     = 1'b0;
        promote  = 1'b0;
        step     = 1'b0;
        unique case (1'b1)
            (state == SCAN_IDLE): begin
                sel_n    = 2'd0;
                sel_en_n = 1'b0;
                if (start) begin
                    state_n  = SCAN_SHOW;
                    sel_en_n = 1'b1;
                    promote  = shadow_full;
                end
            end
            (state != SCAN_IDLE && !start): begin
                state_n  = SCAN_IDLE;
                sel_n    = 2'd0;
                sel_en_n = 1'b0;
            end
            (state == SCAN_SHOW && start): begin
                if (tc) begin
`ifdef SCAN_SEQ_BLANK_EN
                    state_n  = SCAN_BLANK;
                    sel_en_n = 1'b0;
`else
                    step     = 1'b1;
`endif
                end
            end
`ifdef SCAN_SEQ_BLANK_EN
            (state == SCAN_BLANK && start): begin
                if (tc) begin
                    state_n  = SCAN_SHOW;
                    sel_en_n = 1'b1;
                    step     = 1'b1;
                end
            end
`endif
            default: begin
                state_n  = SCAN_IDLE;
                sel_n    = 2'd0;
                sel_en_n = 1'b0;
            end
        endcase
        // leaving index 3 is the frame boundary
        if (step) begin
            sel_n = bus.sel + 2'd1;
            if (bus.sel == 2'(SCAN_N - 1)) begin
                fd_n    = 1'b1;
                promote = shadow_full;
            end
        end
        active_n = promote ? shadow : active;
        digit_n  = active_n[int'(sel_n)*W +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SCAN_IDLE;
            bus.sel        <= 2'd0;
            bus.sel_en     <= 1'b0;
            bus.digit      <= '0;
            bus.frame_done <= 1'b0;
            active         <= '0;
            shadow         <= '0;
            shadow_full    <= 1'b0;
        end else begin
            state          <= state_n;
            bus.sel        <= sel_n;
            bus.sel_en     <= sel_en_n;
            bus.digit      <= digit_n;
            bus.frame_done <= fd_n;
            active         <= active_n;
            if (bus.load_valid && !shadow_full) begin
                shadow      <= bus.load_data;
                shadow_full <= 1'b1;
            end else if (promote) begin
                shadow_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scan_seq.sv
// Bench for scan_seq: reset/load table, then scan, buffer, stop sequences.
module tb_scan_seq;

    localparam int DIV   = 4;
    localparam int BLANK = 2;
    localparam int W     = 4;
`ifdef SCAN_SEQ_BLANK_EN
    localparam int PER = DIV + BLANK;
`else
    localparam int PER = DIV;
`endif
    localparam int FRAME = 4 * PER;

    logic clk = 1'b0;
    logic rst;
    logic start;

    scan_seq_if #(.W(W)) bus ();

    scan_seq #(
        .DIV   (DIV),
        .BLANK (BLANK),
        .W     (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       en;
        logic [3:0] dig;
        logic       fd;
        logic       rdy;
    } exp_t;

    typedef struct {
        logic        r;
        logic        s;
        logic        lv;
        logic [15:0] ld;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nmis = 0;

    bit          m_run  = 1'b0;
    int          m_k    = 0;
    logic [15:0] m_act  = '0;
    logic [15:0] m_sh   = '0;
    bit          m_full = 1'b0;

    function automatic logic [3:0] fld(logic [15:0] f, int i);
        return f[i*4 +: 4];
    endfunction

    function automatic vec_t mk(logic r, logic s, logic lv, logic [15:0] ld,
                                logic [1:0] sel, logic en, logic [3:0] dig,
                                logic fd, logic rdy);
        vec_t v;
        v.r = r;
        v.s = s;
        v.lv = lv;
        v.ld = ld;
        v.e.sel = sel;
        v.e.en = en;
        v.e.dig = dig;
        v.e.fd = fd;
        v.e.rdy = rdy;
        return v;
    endfunction

    // arithmetic reference: position in frame derived from cycles since start
    task automatic model(input logic r, input logic s, input logic lv,
                         input logic [15:0] ld, output exp_t e);
        bit acc;
        bit fd;
        int idx;
        acc = lv && !m_full;
        fd  = 1'b0;
        if (r) begin
            m_run  = 1'b0;
            m_k    = 0;
            m_act  = '0;
            m_sh   = '0;
            m_full = 1'b0;
            acc    = 1'b0;
        end else if (!m_run) begin
            if (s) begin
                m_run = 1'b1;
                m_k   = 0;
                if (m_full) begin
                    m_act  = m_sh;
                    m_full = 1'b0;
                end
            end
        end else if (!s) begin
            m_run = 1'b0;
            m_k   = 0;
        end else begin
            m_k++;
            if (m_k % FRAME == 0) begin
                fd = 1'b1;
                if (m_full) begin
                    m_act  = m_sh;
                    m_full = 1'b0;
                end
            end
        end
        if (acc) begin
            m_sh   = ld;
            m_full = 1'b1;
        end
        idx   = m_run ? (m_k / PER) % 4 : 0;
        e.sel = 2'(idx);
        e.en  = m_run && ((m_k % PER) < DIV);
        e.dig = fld(m_act, idx);
        e.fd  = fd;
        e.rdy = !m_full;
    endtask

    task automatic check(input string nm, input exp_t e);
        nvec++;
        if (bus.sel !== e.sel) begin
            nmis++;
            $display("FAIL %s k=%0d sel got %0d want %0d", nm, m_k, bus.sel, e.sel);
        end
        if (bus.sel_en !== e.en) begin
            nmis++;
            $display("FAIL %s k=%0d sel_en got %0b want %0b", nm, m_k, bus.sel_en, e.en);
        end
        if (bus.digit !== e.dig) begin
            nmis++;
            $display("FAIL %s k=%0d digit got %h want %h", nm, m_k, bus.digit, e.dig);
        end
        if (bus.frame_done !== e.fd) begin
            nmis++;
            $display("FAIL %s k=%0d frame_done got %0b want %0b", nm, m_k, bus.frame_done, e.fd);
        end
        if (bus.load_ready !== e.rdy) begin
            nmis++;
            $display("FAIL %s k=%0d load_ready got %0b want %0b", nm, m_k, bus.load_ready, e.rdy);
        end
    endtask

    task automatic go(input string nm, input logic r, input logic s,
                      input logic lv, input logic [15:0] ld, input exp_t e);
        exp_t g;
        rst            = r;
        start          = s;
        bus.load_valid = lv;
        bus.load_data  = ld;
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check(nm, g);
    endtask

    task automatic step(input string nm, input logic r, input logic s,
                        input logic lv, input logic [15:0] ld);
        exp_t e;
        model(r, s, lv, ld, e);
        go(nm, r, s, lv, ld, e);
    endtask

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        logic        lv;
        logic [15:0] ld;
        exp_t        dummy;

        tbl[0] = mk(1, 1, 0, 16'h0000, 2'd0, 0, 4'h0, 0, 1);
        tbl[1] = mk(1, 0, 1, 16'h4321, 2'd0, 0, 4'h0, 0, 1);
        tbl[2] = mk(0, 0, 1, 16'h4321, 2'd0, 0, 4'h0, 0, 0);
        tbl[3] = mk(0, 0, 1, 16'hAAAA, 2'd0, 0, 4'h0, 0, 0);
        tbl[4] = mk(0, 1, 0, 16'h0000, 2'd0, 1, 4'h1, 0, 1);

        for (int i = 0; i < 5; i++) begin
            model(tbl[i].r, tbl[i].s, tbl[i].lv, tbl[i].ld, dummy);
            go("tbl", tbl[i].r, tbl[i].s, tbl[i].lv, tbl[i].ld, tbl[i].e);
        end

        for (int c = 1; c < FRAME; c++) begin
            lv = 1'b0;
            ld = 16'h0000;
            if (c == PER + 1) begin
                lv = 1'b1;
                ld = 16'h8765;
            end else if (c >= PER + 3 && c <= PER + 6) begin
                lv = 1'b1;
                ld = 16'hAAAA;
            end
            step("frame1", 0, 1, lv, ld);
        end

        for (int c = 0; c < FRAME + 2 * PER + 1; c++) begin
            lv = (c == FRAME + 1);
            step("frame2", 0, 1, lv, 16'hFEDC);
        end

        step("stop", 0, 0, 0, 16'h0000);
        step("idle", 0, 0, 0, 16'h0000);
        step("idle", 0, 0, 1, 16'h1234);
        step("rst_full", 1, 0, 0, 16'h0000);
        step("load2", 0, 0, 1, 16'h3C5A);
        step("start2", 0, 1, 0, 16'h0000);

        for (int c = 1; c < FRAME; c++) begin
            lv = (c == 2);
            step("frame4", 0, 1, lv, 16'h0F0F);
        end

        step("wrap_stop", 0, 0, 0, 16'h0000);
        step("start3", 0, 1, 0, 16'h0000);
        for (int c = 0; c < PER + 2; c++) begin
            step("frame5", 0, 1, 0, 16'h0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
